y86_run_ctrl: RTL
=================

// Module: y86_run_ctrl
// PURPOSE
// - Run/step sequencer for the Y86 core. Gates core advance (cpu_en_o) from host commands (start/step/stop/clear).
// - Samples the per-instruction 2-bit status code at each retire and stops the core on HLT/ADR/INS.
// - Holds the sticky final status and provides cycle and instruction counters for the bench and host.
// PARAMETERS
// - CNT_W       32    width of cycle_cnt_o / instr_cnt_o (saturating)
// - WDOG_LIMIT  1024  cycles without a retire before watchdog trip (used only with RUN_WATCHDOG_EN)
// PORTS
// - clk_i        in   1      clock; all logic on rising edge
// - rst_i        in   1      synchronous reset, active-high
// - start_i      in   1      IDLE -> RUN (level sampled per cycle)
// - step_i       in   1      IDLE -> STEP (execute exactly one instruction)
// - stop_i       in   1      request RUN -> IDLE at the next retire
// - clear_i      in   1      HALT/ERR -> IDLE; clears stat_o and counters
// - retire_i     in   1      one-cycle pulse: an instruction completed this cycle
// - stat_i       in   2      status of the retiring instruction: 00 AOK, 01 HLT, 10 ADR, 11 INS
// - cpu_en_o     out  1      core advance enable
// - state_o      out  3      0 IDLE, 1 RUN, 2 STEP, 3 HALT, 4 ERR
// - stat_o       out  2      sticky status of the last retired instruction
// - busy_o       out  1      1 in RUN or STEP
// - done_o       out  1      one-cycle pulse on entry to HALT or ERR
// - cycle_cnt_o  out  CNT_W  number of cycles with cpu_en_o=1
// - instr_cnt_o  out  CNT_W  number of accepted retires
// - wdog_o       out  1      sticky watchdog-trip flag
// BEHAVIOUR
// - Reset: state=IDLE; stat_o=00; all counters 0; cpu_en_o, busy_o, done_o, wdog_o = 0; stop_pend = 0.
// - Priority each cycle: rst_i > clear_i > retire handling > commands.
// - Outputs cpu_en_o, busy_o and state_o are registered decodes of the current state.
// - cpu_en_o = 1 in RUN, and in STEP until the retire is accepted.
// - IDLE:
//   - start_i -> RUN. start_i and step_i both high: start_i wins.
//   - step_i (start_i low) -> STEP. Entering RUN or STEP clears stop_pend.
// - RUN: stop_i sets stop_pend. stop_i in the same cycle as a retire counts for that retire.
// - Accepted retire: retire_i=1 while cpu_en_o=1.
//   - stat_o <= stat_i; instr_cnt +1.
//   - stat_i AOK: STEP -> IDLE; RUN -> IDLE if stop_pend (or stop_i) is set, else stay in RUN.
//   - stat_i HLT -> HALT.
//   - stat_i ADR or INS -> ERR.
//   - HALT/ERR entry: done_o=1 for exactly one cycle; cpu_en_o=0 from the next cycle.
// - retire_i while cpu_en_o=0 is ignored: no stat update, no count.
// - HALT/ERR: start_i, step_i and stop_i are ignored.
//   - clear_i -> IDLE; stat_o=00; counters=0; wdog_o=0.
// - clear_i in IDLE zeroes the counters and stat_o.
// - clear_i in RUN/STEP is ignored (stop first).
// - Counters saturate at all-ones and never wrap.
//   - cycle_cnt increments in every cycle with cpu_en_o=1, including the retire cycle.
// - Latency: command to cpu_en_o=1 is 1 cycle; accepted retire to state change is 1 cycle.
// - Synchronous reset in any state (including mid-STEP) returns to the reset values on the next edge.
// CONFIGURATION
// - `RUN_WATCHDOG_EN defined:
//   - Idle counter clears on each accepted retire and on every entry to RUN/STEP.
//   - It counts cycles with cpu_en_o=1.
//   - On reaching WDOG_LIMIT: -> ERR, stat_o=10 (ADR), wdog_o=1, done_o pulses.
// - `RUN_WATCHDOG_EN undefined: no idle counter; wdog_o tied 0; RUN may last indefinitely.
// TESTING
// - step_i 1 cycle, retire_i with stat_i=00 three cycles later:
//   - state 0->2->0; instr_cnt=1; cycle_cnt=4; stat_o=00.
// - start_i; 5 AOK retires; then retire with stat_i=01:
//   - state=3, stat_o=01, done_o pulse, instr_cnt=6, cpu_en_o=0.
// - RUN; retire stat_i=11: state=4, stat_o=11. Then start_i ignored; clear_i -> state=0, stat_o=00, counters=0.
// - RUN; stop_i pulsed with no retire: still RUN. Next AOK retire -> IDLE.
// - retire_i stat_i=10 while IDLE: state and stat unchanged. start_i+step_i same cycle -> RUN.
// - With RUN_WATCHDOG_EN and WDOG_LIMIT=16: RUN with no retire for 16 cycles:
//   - state=4, stat_o=10, wdog_o=1.
// - Same test with the macro undefined: stays in RUN.

Source files
------------

// File: rtl/y86_run_ctrl_if.sv
// Host/core signal bundle for the Y86 run/step sequencer.
// The master modport belongs to the host and core; the slave modport belongs to the sequencer.
interface y86_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             step_i;
  logic             stop_i;
  logic             clear_i;
  logic             retire_i;
  logic [1:0]       stat_i;
  logic             cpu_en_o;
  logic [2:0]       state_o;
  logic [1:0]       stat_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] instr_cnt_o;
  logic             wdog_o;

  // Handshake: there is no valid/ready pair. retire_i is a one-cycle pulse, and the
  // sequencer accepts it only in a cycle where cpu_en_o is high. Commands are level
  // samples and are taken on the rising edge where the current state allows them.
  modport master (
    output start_i, step_i, stop_i, clear_i, retire_i, stat_i,
    input  cpu_en_o, state_o, stat_o, busy_o, done_o, cycle_cnt_o, instr_cnt_o, wdog_o
  );

  modport slave (
    input  start_i, step_i, stop_i, clear_i, retire_i, stat_i,
    output cpu_en_o, state_o, stat_o, busy_o, done_o, cycle_cnt_o, instr_cnt_o, wdog_o
  );
endinterface

// File: rtl/y86_run_ctrl.sv
// Run/step sequencer for the Y86 core: gates core advance, tracks retire status, counts cycles and instructions.
// Define RUN_WATCHDOG_EN to build in the no-retire watchdog, which trips into ERR after WDOG_LIMIT enabled cycles.
module y86_run_ctrl #(
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  y86_run_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_STEP = 3'd2,
    S_HALT = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;

  state_t           state_q, state_n;
  logic             stop_pend_q, stop_pend_n;
  logic [1:0]       stat_q, stat_n;
  logic             cpu_en_q, busy_q, done_q;
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
  logic             wdog_q;
  logic             clr;
  logic             retire_acc;
  logic             wd_trip;
  logic             final_n;

  assign retire_acc = bus.retire_i & cpu_en_q;

`ifdef RUN_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_LIMIT - 1);

  logic [WD_W-1:0] wd_cnt_q;

  // The trip fires in the enabled cycle that would bring the idle count up to WDOG_LIMIT.
  assign wd_trip = cpu_en_q & ~retire_acc & (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
    end else if (retire_acc ||
                 ((state_n == S_RUN || state_n == S_STEP) &&
                  state_q != S_RUN && state_q != S_STEP)) begin
      wd_cnt_q <= '0;
    end else if (cpu_en_q && wd_cnt_q != WD_LAST) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^(32'(WDOG_LIMIT));
  assign wd_trip = 1'b0;
`endif

  always_comb begin
    state_n     = state_q;
    stop_pend_n = stop_pend_q;
    stat_n      = stat_q;
    clr         = 1'b0;
    if (bus.clear_i && (state_q == S_IDLE || state_q == S_HALT || state_q == S_ERR)) begin
      state_n = S_IDLE;
      stat_n  = STAT_AOK;
      clr     = 1'b1;
    end else if (retire_acc) begin
      stat_n = bus.stat_i;
      if (bus.stat_i == STAT_AOK) begin
        if (state_q == S_STEP || stop_pend_q || bus.stop_i) begin
          state_n = S_IDLE;
        end
      end else if (bus.stat_i == STAT_HLT) begin
        state_n = S_HALT;
      end else begin
        state_n = S_ERR;
      end
    end else if (wd_trip) begin
      state_n = S_ERR;
      stat_n  = STAT_ADR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            state_n     = S_RUN;
            stop_pend_n = 1'b0;
          end else if (bus.step_i) begin
            state_n     = S_STEP;
            stop_pend_n = 1'b0;
          end
        end
        S_RUN: begin
          if (bus.stop_i) begin
            stop_pend_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign final_n = (state_n == S_HALT || state_n == S_ERR) &&
                   !(state_q == S_HALT || state_q == S_ERR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      stop_pend_q <= 1'b0;
      stat_q      <= STAT_AOK;
      cpu_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wdog_q      <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_n;
      stop_pend_q <= stop_pend_n;
      stat_q      <= stat_n;
      // Output decodes are taken from the next state so they line up with state_q.
      cpu_en_q    <= (state_n == S_RUN || state_n == S_STEP);
      busy_q      <= (state_n == S_RUN || state_n == S_STEP);
      done_q      <= final_n;
      if (clr) begin
        wdog_q      <= 1'b0;
        cycle_cnt_q <= '0;
        instr_cnt_q <= '0;
      end else begin
        if (wd_trip) begin
          wdog_q <= 1'b1;
        end
        if (cpu_en_q && cycle_cnt_q != {CNT_W{1'b1}}) begin
          cycle_cnt_q <= cycle_cnt_q + 1'b1;
        end
        if (retire_acc && instr_cnt_q != {CNT_W{1'b1}}) begin
          instr_cnt_q <= instr_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.cpu_en_o    = cpu_en_q;
  assign bus.state_o     = state_q;
  assign bus.stat_o      = stat_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.cycle_cnt_o = cycle_cnt_q;
  assign bus.instr_cnt_o = instr_cnt_q;
  assign bus.wdog_o      = wdog_q;
endmodule
